// File: rtl/ram_sdp_bw.sv
// Simple-dual-port synchronous RAM with per-byte write enables, 1- or 2-cycle
// read latency, selectable read-during-write policy and out-of-range flagging.
module ram_sdp_bw #(
   parameter int DATA_WIDTH = 32,
   parameter int RAM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter int NUM_BYTES  = DATA_WIDTH / 8,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_BYTES-1:0]  wr_be,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  addr_err
);

   // One extra bit so a power-of-two depth still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  wr_in, rd_in, wr_do;
   logic [DATA_WIDTH-1:0] be_mask;
   logic [DATA_WIDTH-1:0] old_word, rd_word;

   logic                  s1_valid_d, s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;
   logic                  addr_err_d, addr_err_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
         assign be_mask[gi*8 +: 8] = {8{wr_be[gi]}};
      end
   endgenerate

   always_comb begin
      wr_in = ({1'b0, wr_addr} < DEPTH_L);
      rd_in = ({1'b0, rd_addr} < DEPTH_L);
      wr_do = rst_n & wr_en & wr_in;
   end

   always_ff @(posedge clk) begin
      if (wr_do) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (wr_be[i]) mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
         end
      end
   end

   // An out-of-range read returns zero; a matching write can never be in range then.
   always_comb begin
      old_word = '0;
      if (rd_in) old_word = mem[rd_addr];
      rd_word = old_word;
      if ((RDW_MODE == 1) && wr_do && (wr_addr == rd_addr)) begin
         rd_word = (old_word & ~be_mask) | (wr_data & be_mask);
      end
   end

   always_comb begin
      s1_valid_d = rd_en;
      s1_data_d  = rd_en ? rd_word : s1_data_q;
      addr_err_d = (wr_en & ~wr_in) | (rd_en & ~rd_in);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_valid_d, s2_valid_q;
         logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;

         always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
            end else begin
               s2_valid_q <= s2_valid_d;
               s2_data_q  <= s2_data_d;
            end
         end

         assign rd_valid = s2_valid_q;
         assign rd_data  = s2_data_q;
      end else begin : g_lat1
         assign rd_valid = s1_valid_q;
         assign rd_data  = s1_data_q;
      end
   endgenerate

endmodule

// File: tb/tb_ram_sdp_bw.sv
// Bench for ram_sdp_bw: two instances (1024/lat1/read-first, 1000/lat2/write-first)
// share one stimulus stream; a queue-based scoreboard predicts every output cycle.
module tb_ram_sdp_bw;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en;
   logic [9:0]  wr_addr, rd_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;

   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_valid_a, rd_valid_b, addr_err_a, addr_err_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   logic [31:0] mdl [2][1024];
   int          depth [2] = '{1024, 1000};
   int          lat   [2] = '{1, 2};
   int          rdw   [2] = '{0, 1};
   logic        exp_valid [2];
   logic [31:0] exp_data  [2];
   logic        exp_err   [2];

   always #5 clk = ~clk;

   ram_sdp_bw #(.DATA_WIDTH(32), .RAM_DEPTH(1024), .RD_LATENCY(1), .RDW_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .addr_err(addr_err_a));

   ram_sdp_bw #(.DATA_WIDTH(32), .RAM_DEPTH(1000), .RD_LATENCY(2), .RDW_MODE(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .addr_err(addr_err_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
      end
   endtask

   // One clock edge: model what the edge does, then compare both instances.
   task automatic step();
      logic [31:0] w;
      logic        bad;
      exp_t        e;
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            if (d == 0) q0.delete(); else q1.delete();
            exp_valid[d] = 1'b0;
            exp_data[d]  = 32'h0;
            exp_err[d]   = 1'b0;
         end else begin
            bad = (wr_en && int'(wr_addr) >= depth[d]) || (rd_en && int'(rd_addr) >= depth[d]);
            if (rd_en) begin
               w = 32'h0;
               if (int'(rd_addr) < depth[d]) begin
                  w = mdl[d][rd_addr];
                  if (rdw[d] == 1 && wr_en && wr_addr == rd_addr) begin
                     for (int b = 0; b < 4; b++)
                        if (wr_be[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
                  end
               end
               e.due  = cyc + lat[d] - 1;
               e.data = w;
               if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
            exp_valid[d] = 1'b0;
            if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin
               e = q0.pop_front();
               exp_valid[d] = 1'b1;
               exp_data[d]  = e.data;
            end
            if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin
               e = q1.pop_front();
               exp_valid[d] = 1'b1;
               exp_data[d]  = e.data;
            end
            exp_err[d] = bad;
            if (wr_en && int'(wr_addr) < depth[d]) begin
               for (int b = 0; b < 4; b++)
                  if (wr_be[b]) mdl[d][wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            end
         end
      end
      #1;
      check("valid_a", {31'h0, rd_valid_a}, {31'h0, exp_valid[0]});
      check("data_a",  rd_data_a,           exp_data[0]);
      check("err_a",   {31'h0, addr_err_a}, {31'h0, exp_err[0]});
      check("valid_b", {31'h0, rd_valid_b}, {31'h0, exp_valid[1]});
      check("data_b",  rd_data_b,           exp_data[1]);
      check("err_b",   {31'h0, addr_err_b}, {31'h0, exp_err[1]});
      $display("cyc=%0d rst_n=%0b wr=%0b@%0d be=%h d=%h rd=%0b@%0d | A v=%0b d=%h e=%0b | B v=%0b d=%h e=%0b",
               cyc, rst_n, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
               rd_valid_a, rd_data_a, addr_err_a, rd_valid_b, rd_data_b, addr_err_b);
   endtask

   task automatic drive(input logic we, input logic [9:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [9:0] ra);
      wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
      rd_en = re; rd_addr = ra;
      step();
   endtask

   task automatic idle();
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b0, 10'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      repeat (3) idle();
      check("reset_valid_b", {31'h0, rd_valid_b}, 32'h0);
      check("reset_data_a", rd_data_a, 32'h0);
      rst_n = 1'b1;
      idle();

      // Reset mid-read: the lat-2 read in flight must be dropped.
      drive(1'b1, 10'd3, 4'hF, 32'h12345678, 1'b0, 10'd0);
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd3);
      rst_n = 1'b0;
      idle();
      check("rst_mid_valid_b", {31'h0, rd_valid_b}, 32'h0);
      check("rst_mid_data_b", rd_data_b, 32'h0);
      rst_n = 1'b1;
      idle();
      idle();

      // Byte-enable merge.
      drive(1'b1, 10'd5, 4'hF, 32'h11223344, 1'b0, 10'd0);
      drive(1'b1, 10'd5, 4'b0101, 32'hAABBCCDD, 1'b0, 10'd0);
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd5);
      check("be_merge_a", rd_data_a, 32'h11BB33DD);
      idle();
      check("be_merge_b", rd_data_b, 32'h11BB33DD);

      // Read-during-write, full and partial byte enables.
      drive(1'b1, 10'd7, 4'hF, 32'h0, 1'b0, 10'd0);
      drive(1'b1, 10'd7, 4'hF, 32'hDEADBEEF, 1'b1, 10'd7);
      check("rdw_old_a", rd_data_a, 32'h00000000);
      idle();
      check("rdw_new_b", rd_data_b, 32'hDEADBEEF);
      drive(1'b1, 10'd7, 4'b0101, 32'h01020304, 1'b1, 10'd7);
      idle();
      drive(1'b1, 10'd8, 4'hF, 32'hCAFEF00D, 1'b1, 10'd7);
      idle();
      idle();

      // Boundaries: addr 0, 999, 1023, zero-byte-enable write, idle gaps.
      drive(1'b1, 10'd0,    4'hF, 32'hA5A5A5A5, 1'b0, 10'd0);
      drive(1'b1, 10'd999,  4'hF, 32'h0BADF00D, 1'b0, 10'd0);
      drive(1'b1, 10'd1023, 4'hF, 32'h5A5A5A5A, 1'b0, 10'd0);
      drive(1'b1, 10'd0,    4'h0, 32'hFFFFFFFF, 1'b0, 10'd0);
      idle();
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd0);
      idle();
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd999);
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd1023);
      idle();
      idle();

      // Out of range on the 1000-deep instance.
      drive(1'b1, 10'd1000, 4'hF, 32'hFFFFFFFF, 1'b0, 10'd0);
      check("oor_wr_err_b", {31'h0, addr_err_b}, 32'h1);
      idle();
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd1000);
      check("oor_rd_err_b", {31'h0, addr_err_b}, 32'h1);
      drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'd999);
      check("oor_rd_data_b", rd_data_b, 32'h0);
      check("oor_err_clear_b", {31'h0, addr_err_b}, 32'h0);
      idle();
      check("oor_999_b", rd_data_b, 32'h0BADF00D);
      drive(1'b1, 10'd1001, 4'hF, 32'h1, 1'b1, 10'd1002);
      idle();
      idle();

      // Fill then stream back-to-back reads.
      for (int a = 0; a < 1024; a++)
         drive(1'b1, 10'(a), 4'hF, 32'(a * 3), 1'b0, 10'd0);
      for (int a = 0; a < 1024; a++)
         drive(1'b0, 10'd0, 4'h0, 32'h0, 1'b1, 10'(a));
      idle();
      idle();
      idle();
      check("drain_q0", 32'(q0.size()), 32'h0);
      check("drain_q1", 32'(q1.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
